// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential fetch unit sitting in front of instruction decode.
//
// Generates word-aligned fetch addresses and drives an in-order imem request/response
// interface. Returned words are buffered together with their PCs in a small FIFO and
// presented to decode through a valid/ready handshake. A redirect flushes the FIFO,
// and any responses still in flight are discarded before fetch resumes at the new PC.
//
// Ports:
//   clk, rst                        clock; synchronous active-low reset
//   imem_req_o / imem_addr_o        request valid (held until grant) / word address
//   imem_gnt_i                      request accepted this cycle
//   imem_rvalid_i / imem_rdata_i    in-order response valid / instruction word
//   instr_valid_o/instr_o/pc_o      FIFO head presented to decode
//   instr_ready_i                   decode accepts the head
//   redirect_i / redirect_pc_i      one-cycle redirect pulse / new fetch address
//   perf_fetched_o/perf_dropped_o   FIFO-push and discarded-response counters
//                                   (present only when FETCH_PERF_EN is defined)
module instruction_fetch #(
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_dropped_o
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    state_t         state, state_next;
    logic [31:0]    pc;
    logic [OW-1:0]  outstanding, outstanding_next;

    entry_t         fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  fifo_count;

    // Addresses of granted requests, consumed in order as responses return.
    logic [31:0]    tag_mem [MAX_OUTSTANDING];
    logic [TW-1:0]  tag_rd, tag_wr;

    logic           gnt_fire, rsp_fire, redirect_take, push, pop;
    logic [31:0]    credit_used;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        if (32'(p) == MAX_OUTSTANDING - 1) return '0;
        return p + 1'b1;
    endfunction

    // Every outstanding request owns a FIFO slot, so the FIFO can never overflow.
    assign credit_used   = 32'(outstanding) + 32'(fifo_count);
    assign redirect_take = redirect_i && (state != S_BOOT);
    assign rsp_fire      = imem_rvalid_i && (outstanding != '0);

    assign imem_req_o    = (state == S_RUN) && !redirect_i &&
                           (32'(outstanding) < MAX_OUTSTANDING) &&
                           (credit_used < FIFO_DEPTH);
    assign gnt_fire      = imem_req_o && imem_gnt_i;
    assign imem_addr_o   = pc;

    assign outstanding_next = outstanding + OW'(gnt_fire) - OW'(rsp_fire);

    always_comb begin
        state_next = state;
        push       = 1'b0;
        pop        = 1'b0;
        case (state)
            S_BOOT:  state_next = S_RUN;
            S_RUN: begin
                push = rsp_fire && !redirect_i;
                pop  = instr_valid_o && instr_ready_i && !redirect_i;
            end
            S_FLUSH: if (outstanding_next == '0) state_next = S_RUN;
            default: state_next = S_BOOT;
        endcase
        if (redirect_take)
            state_next = (outstanding_next != '0) ? S_FLUSH : S_RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_BOOT;
            pc          <= RESET_PC;
            outstanding <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            if (gnt_fire) tag_wr <= tag_inc(tag_wr);
            if (rsp_fire) tag_rd <= tag_inc(tag_rd);
            if (redirect_take) begin
                pc         <= redirect_pc_i & 32'hFFFF_FFFC;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (gnt_fire) pc <= pc + 32'd4;
                if (push)     wr_ptr <= wr_ptr + 1'b1;
                if (pop)      rd_ptr <= rd_ptr + 1'b1;
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (gnt_fire) tag_mem[tag_wr] <= pc;
        if (push)     fifo_mem[wr_ptr] <= '{instr: imem_rdata_i, pc: tag_mem[tag_rd]};
    end

    // Head is forced to zero when empty so decode never sees stale storage.
    assign instr_valid_o = (fifo_count != '0);
    assign instr_o       = instr_valid_o ? fifo_mem[rd_ptr].instr : '0;
    assign pc_o          = instr_valid_o ? fifo_mem[rd_ptr].pc    : '0;

`ifdef FETCH_PERF_EN
    logic        drop;
    logic [31:0] fetched_cnt, dropped_cnt;

    assign drop = rsp_fire && (redirect_take || (state == S_FLUSH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetched_cnt <= '0;
            dropped_cnt <= '0;
        end else begin
            if (push) fetched_cnt <= fetched_cnt + 32'd1;
            if (drop) dropped_cnt <= dropped_cnt + 32'd1;
        end
    end

    assign perf_fetched_o = fetched_cnt;
    assign perf_dropped_o = dropped_cnt;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run
// against a queue-based model of the fetch stream. Perf counters are checked when
// FETCH_PERF_EN is defined.
module tb_instruction_fetch;

    localparam int          FD  = 4;
    localparam int          MO  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk, rst;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        instr_valid_o, instr_ready_i, redirect_i;
    logic [31:0] instr_o, pc_o, redirect_pc_i;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_o, perf_dropped_o;
`endif

    instruction_fetch #(.FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o),
        .instr_ready_i(instr_ready_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
`ifdef FETCH_PERF_EN
        , .perf_fetched_o(perf_fetched_o), .perf_dropped_o(perf_dropped_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model state: addresses granted but not yet answered, in order.
    logic [31:0] pend_q[$];
    bit          mem_auto;
    int          gnt_pct, rsp_pct;

    // Per-cycle observations, taken just before the rising edge.
    logic        obs_req, obs_valid, obs_gnt, obs_rsp;
    logic [31:0] obs_addr, obs_instr, obs_pc, obs_rsp_addr;
    int          obs_pend;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock: optionally drive the memory side, observe, advance to the next negedge.
    task automatic tick();
        if (mem_auto) begin
            imem_gnt_i    = ($urandom_range(99) < gnt_pct);
            imem_rvalid_i = (pend_q.size() > 0) && ($urandom_range(99) < rsp_pct);
        end
        if (imem_rvalid_i && pend_q.size() > 0) imem_rdata_i = mem_word(pend_q[0]);
        #1;
        obs_req   = imem_req_o;
        obs_addr  = imem_addr_o;
        obs_valid = instr_valid_o;
        obs_instr = instr_o;
        obs_pc    = pc_o;
        obs_pend  = pend_q.size();
        obs_rsp   = imem_rvalid_i && (pend_q.size() > 0) && rst;
        obs_gnt   = obs_req && imem_gnt_i && rst;
        if (obs_rsp) obs_rsp_addr = pend_q.pop_front();
        if (obs_gnt) pend_q.push_back(obs_addr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; mem_auto = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
        pend_q.delete();
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_auto = 1'b0; pend_q.delete();
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        instr_ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        tick(); tick();
        n_checks++; if (obs_req !== 1'b0) begin n_errors++; $display("FAIL reset_req got %0b want 0", obs_req); end
        n_checks++; if (obs_addr !== RPC) begin n_errors++; $display("FAIL reset_addr got %h want %h", obs_addr, RPC); end
        n_checks++; if (obs_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0b want 0", obs_valid); end
        n_checks++; if (obs_instr !== 32'h0) begin n_errors++; $display("FAIL reset_instr got %h want 0", obs_instr); end
        n_checks++; if (obs_pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc got %h want 0", obs_pc); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetched_o !== 32'h0 || perf_dropped_o !== 32'h0) begin
            n_errors++; $display("FAIL reset_perf got %h/%h want 0/0", perf_fetched_o, perf_dropped_o); end
`endif
        rst = 1'b1; imem_rvalid_i = 1'b0;
        tick();
        n_checks++; if (obs_req !== 1'b0) begin n_errors++; $display("FAIL boot_req got %0b want 0", obs_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_a, exp_p;
        int first_v, n_g, n_p;
        do_reset();
        mem_auto = 1'b1; gnt_pct = 100; rsp_pct = 100; instr_ready_i = 1'b1;
        exp_a = RPC; exp_p = RPC; first_v = 0; n_g = 0; n_p = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (obs_gnt) begin
                n_checks++; if (obs_addr !== exp_a) begin n_errors++; $display("FAIL seq_addr got %h want %h", obs_addr, exp_a); end
                exp_a += 32'd4; n_g++;
            end
            if (obs_valid) begin
                if (first_v == 0) first_v = t;
                n_checks++; if (obs_pc !== exp_p || obs_instr !== mem_word(exp_p)) begin
                    n_errors++; $display("FAIL seq_head got %h/%h want %h/%h", obs_pc, obs_instr, exp_p, mem_word(exp_p)); end
                exp_p += 32'd4; n_p++;
            end
        end
        n_checks++; if (first_v != 4) begin n_errors++; $display("FAIL seq_first_valid got %0d want 4", first_v); end
        n_checks++; if (n_g != 19) begin n_errors++; $display("FAIL seq_grants got %0d want 19", n_g); end
        n_checks++; if (n_p != 17) begin n_errors++; $display("FAIL seq_pops got %0d want 17", n_p); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_p;
        int n_g, n_p;
        do_reset();
        mem_auto = 1'b1; gnt_pct = 100; rsp_pct = 100; instr_ready_i = 1'b0;
        n_g = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (obs_gnt) n_g++;
            if (obs_valid) begin
                n_checks++; if (obs_pc !== RPC) begin n_errors++; $display("FAIL stall_head got %h want %h", obs_pc, RPC); end
            end
        end
        n_checks++; if (n_g != 4) begin n_errors++; $display("FAIL stall_grants got %0d want 4", n_g); end
        n_checks++; if (obs_req !== 1'b0) begin n_errors++; $display("FAIL stall_req got %0b want 0", obs_req); end
        gnt_pct = 0; instr_ready_i = 1'b1; exp_p = RPC; n_p = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (obs_valid) begin
                n_checks++; if (obs_pc !== exp_p || obs_instr !== mem_word(exp_p)) begin
                    n_errors++; $display("FAIL drain_head got %h/%h want %h/%h", obs_pc, obs_instr, exp_p, mem_word(exp_p)); end
                exp_p += 32'd4; n_p++;
            end
        end
        n_checks++; if (n_p != 4) begin n_errors++; $display("FAIL drain_count got %0d want 4", n_p); end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        imem_gnt_i = 1'b1; instr_ready_i = 1'b1;
        tick(); tick(); tick();                       // boot, grant 0x0, grant 0x4
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_1003;
        tick();
        n_checks++; if (obs_req !== 1'b0) begin n_errors++; $display("FAIL rf_redirect_req got %0b want 0", obs_req); end
        redirect_i = 1'b0; imem_rvalid_i = 1'b1;
        for (int t = 0; t < 2; t++) begin
            tick();
            n_checks++; if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
                n_errors++; $display("FAIL rf_flush req/valid got %0b/%0b want 0/0", obs_req, obs_valid); end
        end
        imem_rvalid_i = 1'b0;
        tick();
        n_checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0000_1000) begin
            n_errors++; $display("FAIL rf_resume req/addr got %0b/%h want 1/00001000", obs_req, obs_addr); end
        n_checks++; if (obs_valid !== 1'b0) begin n_errors++; $display("FAIL rf_stale_valid got %0b want 0", obs_valid); end
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1;
        tick();
        imem_rvalid_i = 1'b0;
        tick();
        n_checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'h1000 || obs_instr !== mem_word(32'h1000)) begin
            n_errors++; $display("FAIL rf_head got %0b/%h/%h want 1/00001000/%h", obs_valid, obs_pc, obs_instr, mem_word(32'h1000)); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_dropped_o !== 32'd2 || perf_fetched_o !== 32'd1) begin
            n_errors++; $display("FAIL rf_perf got %0d/%0d want fetched 1 dropped 2", perf_fetched_o, perf_dropped_o); end
`endif
    endtask

    task automatic test_redirect_collide();
        do_reset();
        imem_gnt_i = 1'b1;
        tick(); tick(); tick();                       // boot, grant 0x0, grant 0x4
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1;
        tick();                                       // 0x0 lands in the FIFO
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_2000; instr_ready_i = 1'b1;
        tick();                                       // 0x4 response collides with redirect
        n_checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0 || obs_req !== 1'b0) begin
            n_errors++; $display("FAIL rc_pre valid/pc/req got %0b/%h/%0b want 1/0/0", obs_valid, obs_pc, obs_req); end
        redirect_i = 1'b0; imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
        tick();
        n_checks++; if (obs_valid !== 1'b0) begin n_errors++; $display("FAIL rc_empty got %0b want 0", obs_valid); end
        n_checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h2000) begin
            n_errors++; $display("FAIL rc_issue req/addr got %0b/%h want 1/00002000", obs_req, obs_addr); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetched_o !== 32'd1 || perf_dropped_o !== 32'd1) begin
            n_errors++; $display("FAIL rc_perf got %0d/%0d want 1/1", perf_fetched_o, perf_dropped_o); end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        tick();                                       // boot
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
        tick();
        redirect_i = 1'b0; imem_gnt_i = 1'b1;
        tick();
        n_checks++; if (obs_req !== 1'b1 || obs_addr !== 32'hFFFF_FFFC) begin
            n_errors++; $display("FAIL wrap_addr0 got %0b/%h want 1/fffffffc", obs_req, obs_addr); end
        imem_rvalid_i = 1'b1;
        tick();
        n_checks++; if (obs_addr !== 32'h0) begin n_errors++; $display("FAIL wrap_addr1 got %h want 0", obs_addr); end
        imem_gnt_i = 1'b0;
        tick();
        imem_rvalid_i = 1'b0;
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        tick();                                       // response with nothing outstanding
        imem_rvalid_i = 1'b0; instr_ready_i = 1'b1;
        tick();
        n_checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'hFFFF_FFFC || obs_instr !== mem_word(32'hFFFF_FFFC)) begin
            n_errors++; $display("FAIL wrap_head0 got %0b/%h/%h", obs_valid, obs_pc, obs_instr); end
        tick();
        n_checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0 || obs_instr !== mem_word(32'h0)) begin
            n_errors++; $display("FAIL wrap_head1 got %0b/%h/%h", obs_valid, obs_pc, obs_instr); end
        tick();
        n_checks++; if (obs_valid !== 1'b0) begin n_errors++; $display("FAIL wrap_spurious got %0b want 0", obs_valid); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetched_o !== 32'd2) begin n_errors++; $display("FAIL wrap_perf got %0d want 2", perf_fetched_o); end
`endif
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        mem_auto = 1'b1; gnt_pct = 100; rsp_pct = 100;
        tick(); tick(); tick(); tick();               // two buffered, one outstanding
        mem_auto = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_3000;
        tick();
        redirect_i = 1'b0;
        tick();
        n_checks++; if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
            n_errors++; $display("FAIL rm_flush req/valid got %0b/%0b want 0/0", obs_req, obs_valid); end
        rst = 1'b0;
        tick();
        pend_q.delete();
        rst = 1'b1; imem_rvalid_i = 1'b1; imem_gnt_i = 1'b1;
        tick();
        n_checks++; if (obs_req !== 1'b0 || obs_addr !== RPC || obs_valid !== 1'b0 || obs_instr !== 32'h0 || obs_pc !== 32'h0) begin
            n_errors++; $display("FAIL rm_reset got req %0b addr %h valid %0b instr %h pc %h", obs_req, obs_addr, obs_valid, obs_instr, obs_pc); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetched_o !== 32'h0 || perf_dropped_o !== 32'h0) begin
            n_errors++; $display("FAIL rm_perf got %0d/%0d want 0/0", perf_fetched_o, perf_dropped_o); end
`endif
        tick();
        n_checks++; if (obs_req !== 1'b1 || obs_addr !== RPC) begin
            n_errors++; $display("FAIL rm_restart got %0b/%h want 1/%h", obs_req, obs_addr, RPC); end
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b0;
        tick();
        n_checks++; if (obs_valid !== 1'b0) begin n_errors++; $display("FAIL rm_late_rsp got %0b want 0", obs_valid); end
    endtask

    task automatic test_random();
        logic [31:0] fifo_q[$];
        logic [31:0] exp_issue, tgt;
        logic        exp_req, redir;
        int          stale, fetched, dropped;
        do_reset();
        mem_auto = 1'b1; gnt_pct = 70; rsp_pct = 60;
        exp_issue = RPC; stale = 0; fetched = 0; dropped = 0;
        tick();
        n_checks++; if (obs_req !== 1'b0) begin n_errors++; $display("FAIL rnd_boot_req got %0b want 0", obs_req); end
        for (int c = 0; c < 1500; c++) begin
            redir = ($urandom_range(99) < 4);
            tgt   = $urandom;
            redirect_i = redir; redirect_pc_i = tgt;
            instr_ready_i = ($urandom_range(99) < 70);
            tick();
            exp_req = !redir && (stale == 0) && (obs_pend < MO) && ((obs_pend + fifo_q.size()) < FD);
            n_checks++; if (obs_req !== exp_req) begin
                n_errors++; $display("FAIL rnd_req cyc %0d got %0b want %0b", c, obs_req, exp_req); end
            if (obs_req) begin
                n_checks++; if (obs_addr !== exp_issue) begin
                    n_errors++; $display("FAIL rnd_addr cyc %0d got %h want %h", c, obs_addr, exp_issue); end
            end
            n_checks++; if (obs_valid !== (fifo_q.size() != 0)) begin
                n_errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", c, obs_valid, fifo_q.size() != 0); end
            if (fifo_q.size() != 0) begin
                n_checks++; if (obs_pc !== fifo_q[0] || obs_instr !== mem_word(fifo_q[0])) begin
                    n_errors++; $display("FAIL rnd_head cyc %0d got %h/%h want %h/%h", c, obs_pc, obs_instr, fifo_q[0], mem_word(fifo_q[0])); end
            end
            if (redir) begin
                if (obs_rsp) dropped++;
                fifo_q.delete();
                stale = pend_q.size();
                exp_issue = {tgt[31:2], 2'b00};
            end else begin
                if (obs_gnt) exp_issue += 32'd4;
                if (fifo_q.size() != 0 && instr_ready_i) void'(fifo_q.pop_front());
                if (obs_rsp) begin
                    if (stale > 0) begin stale--; dropped++; end
                    else begin fifo_q.push_back(obs_rsp_addr); fetched++; end
                end
            end
        end
        redirect_i = 1'b0;
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetched_o !== 32'(fetched) || perf_dropped_o !== 32'(dropped)) begin
            n_errors++; $display("FAIL rnd_perf got %0d/%0d want %0d/%0d", perf_fetched_o, perf_dropped_o, fetched, dropped); end
`endif
    endtask

    initial begin
        rst = 1'b0; mem_auto = 1'b0; gnt_pct = 0; rsp_pct = 0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_flush();
        test_redirect_collide();
        test_wrap();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
